// File: rtl/audio_fetch_arbiter.sv
// audio_fetch_arbiter
// Shares one VRAM/TILE read port among CHANNELS audio mixer channels.
// Each channel's fetch request level is registered and edge-detected; a
// rising edge marks the channel pending and captures its sample address.
// Pending channels are granted round-robin, only in cycles where the memory
// port is free (slot_i) and fetching is enabled. Each returned word lands in
// the requesting channel's word register with a one-cycle valid pulse.
//
// Ports:
//   clk, reset_n_i        clock, asynchronous active-low reset
//   enable_i              low blocks new grants (in-flight reads complete)
//   fetch_i, addr_i       per-channel request level and packed address
//   word_o, word_valid_o  per-channel last fetched word and update pulse
//   slot_i                memory port free this cycle
//   mem_sel_o, mem_addr_o read request and address to the memory arbiter
//   mem_ack_i, mem_data_i read completion and data (same cycle)
//   overrun_o             sticky per-channel overrun flags
//   overrun_clr_i         clears overrun_o (and timeout_o)
//   timeout_o             sticky watchdog flag (tied 0 unless enabled)
//
// Optional feature: define AUDIO_FETCH_TIMEOUT_EN to add a 6-bit watchdog
// that abandons a read after 63 cycles in REQ without mem_ack_i.

module audio_fetch_arbiter #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n_i,
  input  logic                       enable_i,
  input  logic [CHANNELS-1:0]        fetch_i,
  input  logic [CHANNELS*ADDR_W-1:0] addr_i,
  output logic [CHANNELS*DATA_W-1:0] word_o,
  output logic [CHANNELS-1:0]        word_valid_o,
  input  logic                       slot_i,
  output logic                       mem_sel_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic                       mem_ack_i,
  input  logic [DATA_W-1:0]          mem_data_i,
  output logic [CHANNELS-1:0]        overrun_o,
  input  logic                       overrun_clr_i,
  output logic                       timeout_o
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                      state_q, state_d;
  logic [CHANNELS-1:0]         fetch_q, fetch_d;
  logic [CHANNELS-1:0]         fetch_prev_q, fetch_prev_d;
  logic [CHANNELS*ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]           req_addr_q [CHANNELS];
  logic [ADDR_W-1:0]           req_addr_d [CHANNELS];
  logic [CHANNELS-1:0]         pending_q, pending_d;
  logic [CHANNELS-1:0]         overrun_q, overrun_d;
  logic [IDX_W-1:0]            grant_q, grant_d;
  logic [IDX_W-1:0]            last_grant_q, last_grant_d;
  logic                        mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]           word_q [CHANNELS];
  logic [DATA_W-1:0]           word_d [CHANNELS];
  logic [CHANNELS-1:0]         word_valid_q, word_valid_d;

  logic [CHANNELS-1:0]         rise;
  logic [CHANNELS-1:0]         done_clr;
  logic [CHANNELS-1:0]         ovr_set;
  logic                        sel_found;
  logic [IDX_W-1:0]            sel_idx;
  int                          cand;

`ifdef AUDIO_FETCH_TIMEOUT_EN
  logic [5:0]                  wd_q, wd_d;
  logic                        timeout_q, timeout_d;
`endif

  always_comb begin
    state_d      = state_q;
    fetch_d      = fetch_i;
    fetch_prev_d = fetch_q;
    addr_d       = addr_i;
    req_addr_d   = req_addr_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_sel_d    = mem_sel_q;
    mem_addr_d   = mem_addr_q;
    word_d       = word_q;
    word_valid_d = '0;
    done_clr     = '0;
    ovr_set      = '0;
    sel_found    = 1'b0;
    sel_idx      = '0;
    cand         = 0;
`ifdef AUDIO_FETCH_TIMEOUT_EN
    wd_d         = wd_q;
    timeout_d    = overrun_clr_i ? 1'b0 : timeout_q;
`endif

    // Edge detect on the registered request so the captured address is the
    // one sampled together with the rising level.
    rise = fetch_q & ~fetch_prev_q;

    // Circular search for the first pending channel after the last grant.
    for (int i = 1; i <= CHANNELS; i++) begin
      cand = int'(last_grant_q) + i;
      if (cand >= CHANNELS) cand = cand - CHANNELS;
      if (!sel_found && pending_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end

    case (state_q)
      IDLE: begin
        if (enable_i && slot_i && sel_found) begin
          state_d    = REQ;
          mem_sel_d  = 1'b1;
          mem_addr_d = req_addr_q[sel_idx];
          grant_d    = sel_idx;
`ifdef AUDIO_FETCH_TIMEOUT_EN
          wd_d       = '0;
`endif
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          word_d[grant_q]       = mem_data_i;
          word_valid_d[grant_q] = 1'b1;
          done_clr[grant_q]     = 1'b1;
          mem_sel_d             = 1'b0;
          last_grant_d          = grant_q;
          state_d               = IDLE;
        end
`ifdef AUDIO_FETCH_TIMEOUT_EN
        // wd_q counts completed REQ cycles; the 63rd cycle abandons the read.
        else if (wd_q == 6'd62) begin
          done_clr[grant_q] = 1'b1;
          mem_sel_d         = 1'b0;
          last_grant_d      = grant_q;
          timeout_d         = 1'b1;
          state_d           = IDLE;
        end else begin
          wd_d = wd_q + 6'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // A fresh edge beats a completing read on the same channel: the request
    // stays pending with the new address and is not counted as an overrun.
    for (int c = 0; c < CHANNELS; c++) begin
      if (rise[c]) begin
        req_addr_d[c] = addr_q[c*ADDR_W +: ADDR_W];
        if (pending_q[c] && !done_clr[c]) ovr_set[c] = 1'b1;
      end
    end

    pending_d = (pending_q & ~done_clr) | rise;
    overrun_d = (overrun_q & ~{CHANNELS{overrun_clr_i}}) | ovr_set;
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      fetch_q      <= '0;
      fetch_prev_q <= '0;
      addr_q       <= '0;
      req_addr_q   <= '{default: '0};
      pending_q    <= '0;
      overrun_q    <= '0;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(CHANNELS - 1);
      mem_sel_q    <= 1'b0;
      mem_addr_q   <= '0;
      word_q       <= '{default: '0};
      word_valid_q <= '0;
`ifdef AUDIO_FETCH_TIMEOUT_EN
      wd_q         <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_q      <= fetch_d;
      fetch_prev_q <= fetch_prev_d;
      addr_q       <= addr_d;
      req_addr_q   <= req_addr_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_sel_q    <= mem_sel_d;
      mem_addr_q   <= mem_addr_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
`ifdef AUDIO_FETCH_TIMEOUT_EN
      wd_q         <= wd_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_word
    assign word_o[g*DATA_W +: DATA_W] = word_q[g];
  end

  assign word_valid_o = word_valid_q;
  assign mem_sel_o    = mem_sel_q;
  assign mem_addr_o   = mem_addr_q;
  assign overrun_o    = overrun_q;

`ifdef AUDIO_FETCH_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_audio_fetch_arbiter.sv
// Testbench for audio_fetch_arbiter (CHANNELS=4, ADDR_W=16, DATA_W=16).
// A cycle table covers the single-request flow; directed sequences cover
// round-robin order, slot/enable gating, overrun, ack/edge collision,
// reset during a read and, when AUDIO_FETCH_TIMEOUT_EN is defined, the
// watchdog.

module tb_audio_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        enable_i;
  logic [3:0]  fetch_i;
  logic [63:0] addr_i;
  logic [63:0] word_o;
  logic [3:0]  word_valid_o;
  logic        slot_i;
  logic        mem_sel_o;
  logic [15:0] mem_addr_o;
  logic        mem_ack_i;
  logic [15:0] mem_data_i;
  logic [3:0]  overrun_o;
  logic        overrun_clr_i;
  logic        timeout_o;

  int n_vectors     = 0;
  int n_miscompares = 0;

  audio_fetch_arbiter #(.CHANNELS(4), .ADDR_W(16), .DATA_W(16)) dut (
    .clk           (clk),
    .reset_n_i     (reset_n_i),
    .enable_i      (enable_i),
    .fetch_i       (fetch_i),
    .addr_i        (addr_i),
    .word_o        (word_o),
    .word_valid_o  (word_valid_o),
    .slot_i        (slot_i),
    .mem_sel_o     (mem_sel_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i),
    .overrun_o     (overrun_o),
    .overrun_clr_i (overrun_clr_i),
    .timeout_o     (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  fetch;
    logic [63:0] addr;
    logic        en;
    logic        slot;
    logic        ack;
    logic [15:0] data;
    logic        exp_sel;
    logic [15:0] exp_addr;
    logic [3:0]  exp_valid;
    logic [63:0] exp_word;
  } vec_t;

  vec_t vecs[8];

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one table row at the falling edge, then check just after the
  // following rising edge.
  task automatic applyStimulus(input vec_t v, input int k);
    @(negedge clk);
    fetch_i    = v.fetch;
    addr_i     = v.addr;
    enable_i   = v.en;
    slot_i     = v.slot;
    mem_ack_i  = v.ack;
    mem_data_i = v.data;
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d_sel", k), 64'(mem_sel_o), 64'(v.exp_sel));
    checkOutput($sformatf("vec%0d_addr", k), 64'(mem_addr_o), 64'(v.exp_addr));
    checkOutput($sformatf("vec%0d_valid", k), 64'(word_valid_o), 64'(v.exp_valid));
    checkOutput($sformatf("vec%0d_word", k), word_o, v.exp_word);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n_i     = 1'b0;
    enable_i      = 1'b1;
    fetch_i       = '0;
    addr_i        = '0;
    slot_i        = 1'b0;
    mem_ack_i     = 1'b0;
    mem_data_i    = '0;
    overrun_clr_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_n_i = 1'b1;
  endtask

  // Wait (bounded) for mem_sel_o at a falling edge and check the address.
  task automatic waitGrant(input logic [15:0] exp_addr, input string name,
                           output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_sel_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput({name, "_grant"}, 64'(mem_sel_o), 64'd1);
    else       checkOutput({name, "_addr"}, 64'(mem_addr_o), 64'(exp_addr));
  endtask

  // Grant, then acknowledge immediately and check the word return.
  task automatic serviceGrant(input logic [15:0] exp_addr, input logic [15:0] data,
                              input int ch, input string name);
    logic seen;
    logic [3:0] ev;
    waitGrant(exp_addr, name, seen);
    if (seen) begin
      mem_ack_i  = 1'b1;
      mem_data_i = data;
      @(posedge clk);
      #1;
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      ev = 4'b0001 << ch;
      checkOutput({name, "_valid"}, 64'(word_valid_o), 64'(ev));
      checkOutput({name, "_word"}, 64'(word_o[ch*16 +: 16]), 64'(data));
    end
  endtask

  task automatic dropFetch();
    @(negedge clk);
    fetch_i = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic seen;
    logic any_valid;
    int   cnt;

    reset_n_i = 1'b0;
    doReset();
    @(posedge clk);
    #1;
    checkOutput("rst_word", word_o, 64'd0);
    checkOutput("rst_valid", 64'(word_valid_o), 64'd0);
    checkOutput("rst_sel", 64'(mem_sel_o), 64'd0);
    checkOutput("rst_addr", 64'(mem_addr_o), 64'd0);
    checkOutput("rst_overrun", 64'(overrun_o), 64'd0);
    checkOutput("rst_timeout", 64'(timeout_o), 64'd0);

    // Single request on channel 1: grant two cycles after the sampled edge,
    // ack three cycles after mem_sel_o, then no re-grant (pending cleared).
    vecs[0] = '{4'b0010, 64'h0000_0000_1234_0000, 1, 1, 0, 16'h0000, 0, 16'h0000, 4'b0000, 64'd0};
    vecs[1] = '{4'b0010, 64'h0000_0000_1234_0000, 1, 1, 0, 16'h0000, 0, 16'h0000, 4'b0000, 64'd0};
    vecs[2] = '{4'b0010, 64'h0000_0000_1234_0000, 1, 1, 0, 16'h0000, 1, 16'h1234, 4'b0000, 64'd0};
    vecs[3] = '{4'b0010, 64'h0000_0000_1234_0000, 1, 1, 0, 16'h0000, 1, 16'h1234, 4'b0000, 64'd0};
    vecs[4] = '{4'b0010, 64'h0000_0000_1234_0000, 1, 1, 0, 16'h0000, 1, 16'h1234, 4'b0000, 64'd0};
    vecs[5] = '{4'b0010, 64'h0000_0000_1234_0000, 1, 1, 1, 16'hA55A, 0, 16'h1234, 4'b0010,
                64'h0000_0000_A55A_0000};
    vecs[6] = '{4'b0010, 64'h0000_0000_1234_0000, 1, 1, 0, 16'h0000, 0, 16'h1234, 4'b0000,
                64'h0000_0000_A55A_0000};
    vecs[7] = '{4'b0010, 64'h0000_0000_1234_0000, 1, 1, 0, 16'h0000, 0, 16'h1234, 4'b0000,
                64'h0000_0000_A55A_0000};
    for (int k = 0; k < 8; k++) applyStimulus(vecs[k], k);
    mem_ack_i = 1'b0;

    // Round-robin: 0,2,3 together; then 0+2 after last=3 (wrap to 0 first);
    // then 0+3 after last=2 (3 before 0).
    doReset();
    slot_i  = 1'b1;
    addr_i  = {16'h0A03, 16'h0A02, 16'h0000, 16'h0A00};
    fetch_i = 4'b1101;
    serviceGrant(16'h0A00, 16'h1100, 0, "rr_first");
    serviceGrant(16'h0A02, 16'h1102, 2, "rr_second");
    serviceGrant(16'h0A03, 16'h1103, 3, "rr_third");
    dropFetch();
    fetch_i = 4'b0101;
    serviceGrant(16'h0A00, 16'h2200, 0, "rr_wrap_ch0");
    serviceGrant(16'h0A02, 16'h2202, 2, "rr_then_ch2");
    dropFetch();
    fetch_i = 4'b1001;
    serviceGrant(16'h0A03, 16'h3303, 3, "rr_ch3_before_ch0");
    serviceGrant(16'h0A00, 16'h3300, 0, "rr_ch0_last");

    // Slot gating, then enable gating, then grant on the cycle after enable.
    doReset();
    slot_i  = 1'b0;
    addr_i  = 64'h0000_0000_0B01_0000;
    fetch_i = 4'b0010;
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (mem_sel_o) seen = 1'b1;
    end
    checkOutput("slot_gate", 64'(seen), 64'd0);
    enable_i = 1'b0;
    slot_i   = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (mem_sel_o) seen = 1'b1;
    end
    checkOutput("enable_gate", 64'(seen), 64'd0);
    enable_i = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("enable_grant_sel", 64'(mem_sel_o), 64'd1);
    checkOutput("enable_grant_addr", 64'(mem_addr_o), 64'h0B01);
    @(negedge clk);
    mem_ack_i  = 1'b1;
    mem_data_i = 16'h4444;
    @(posedge clk);
    #1;
    mem_ack_i = 1'b0;
    checkOutput("enable_ack_valid", 64'(word_valid_o), 64'b0010);

    // Overrun: two edges on channel 2 before any slot; latest address wins.
    doReset();
    addr_i  = 64'h0000_0100_0000_0000;
    fetch_i = 4'b0100;
    repeat (4) @(negedge clk);
    fetch_i = 4'b0000;
    repeat (3) @(negedge clk);
    addr_i  = 64'h0000_0200_0000_0000;
    fetch_i = 4'b0100;
    repeat (4) @(negedge clk);
    checkOutput("ovr_set", 64'(overrun_o), 64'b0100);
    slot_i = 1'b1;
    serviceGrant(16'h0200, 16'h5555, 2, "ovr_latest");
    checkOutput("ovr_sticky", 64'(overrun_o), 64'b0100);
    @(negedge clk);
    overrun_clr_i = 1'b1;
    @(posedge clk);
    #1;
    overrun_clr_i = 1'b0;
    checkOutput("ovr_clear", 64'(overrun_o), 64'd0);

    // Collision: a new channel-1 edge lands in the same cycle as its ack.
    doReset();
    slot_i  = 1'b1;
    addr_i  = 64'h0000_0000_0C01_0000;
    fetch_i = 4'b0010;
    waitGrant(16'h0C01, "coll_first", seen);
    fetch_i = 4'b0000;
    repeat (3) @(negedge clk);
    checkOutput("coll_hold_sel", 64'(mem_sel_o), 64'd1);
    addr_i  = 64'h0000_0000_0C11_0000;
    fetch_i = 4'b0010;
    @(negedge clk);
    mem_ack_i  = 1'b1;
    mem_data_i = 16'h7777;
    @(posedge clk);
    #1;
    mem_ack_i = 1'b0;
    checkOutput("coll_valid", 64'(word_valid_o), 64'b0010);
    checkOutput("coll_no_overrun", 64'(overrun_o), 64'd0);
    serviceGrant(16'h0C11, 16'h8888, 1, "coll_refetch");

    // Reset during a read: everything returns to reset values at once and
    // the fetch is not replayed.
    dropFetch();
    addr_i  = 64'h0D03_0000_0000_0000;
    fetch_i = 4'b1000;
    waitGrant(16'h0D03, "rstreq", seen);
    reset_n_i = 1'b0;
    fetch_i   = 4'b0000;
    #1;
    checkOutput("rstreq_sel", 64'(mem_sel_o), 64'd0);
    checkOutput("rstreq_addr", 64'(mem_addr_o), 64'd0);
    checkOutput("rstreq_word", word_o, 64'd0);
    repeat (3) @(negedge clk);
    reset_n_i = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (mem_sel_o) seen = 1'b1;
    end
    checkOutput("rstreq_no_replay", 64'(seen), 64'd0);

`ifdef AUDIO_FETCH_TIMEOUT_EN
    // Watchdog: mem_sel_o held exactly 63 cycles, no word update.
    doReset();
    slot_i  = 1'b1;
    addr_i  = 64'h0000_0000_0000_0E00;
    fetch_i = 4'b0001;
    waitGrant(16'h0E00, "wd", seen);
    cnt = 1;
    any_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (word_valid_o != 4'b0000) any_valid = 1'b1;
      if (mem_sel_o) cnt++;
      else break;
    end
    checkOutput("wd_cycles", 64'(cnt), 64'd63);
    checkOutput("wd_timeout", 64'(timeout_o), 64'd1);
    checkOutput("wd_no_valid", 64'(any_valid), 64'd0);
    checkOutput("wd_word", word_o, 64'd0);
`else
    cnt = 0;
    any_valid = 1'b0;
    checkOutput("timeout_tied", 64'(timeout_o), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
